// File: rtl/vga_pkg.sv
// Shared 800x600@72 Hz timing constants, interior bounds and the bounce-step helper
// used by the display generator and vga_box_mover.
package vga_pkg;

  localparam int unsigned H_TOTAL  = 1040;
  localparam int unsigned V_TOTAL  = 666;
  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned V_ACTIVE = 600;
  localparam int unsigned H_START  = 187;
  localparam int unsigned V_START  = 31;

  localparam int unsigned INT_LEFT   = 221;
  localparam int unsigned INT_RIGHT  = 579;
  localparam int unsigned INT_TOP    = 161;
  localparam int unsigned INT_BOTTOM = 439;

  localparam int unsigned AXW = 11;

  typedef struct packed {
    logic [AXW-1:0] pos;
    logic           dir;
    logic           bounced;
  } axis_t;

  // One step on one axis; hi is the largest legal origin, lo the smallest.
  function automatic axis_t axis_step(input logic [AXW-1:0] pos, input logic dir,
                                      input logic [AXW-1:0] lo, input logic [AXW-1:0] hi,
                                      input logic [AXW-1:0] step);
    axis_t          r;
    logic [AXW-1:0] nx;
    r.pos     = pos;
    r.dir     = dir;
    r.bounced = 1'b0;
    nx        = pos + step;
    if (dir) begin
      if (nx >= hi) begin
        r.pos     = hi;
        r.dir     = 1'b0;
        r.bounced = 1'b1;
      end else begin
        r.pos = nx;
      end
    end else if (pos <= lo + step) begin
      r.pos     = lo;
      r.dir     = 1'b1;
      r.bounced = 1'b1;
    end else begin
      r.pos = pos - step;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button debouncer: emits a one-cycle press pulse once the synchronized key
// has been low and stable for DEB_CYCLES clocks after being released.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic press
);

  localparam int unsigned CW = $clog2(DEB_CYCLES) + 1;

  logic          last_q, last_d;
  logic          state_q, state_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter restarts on every input change and saturates once stable.
  always_comb begin
    last_d  = key_in;
    state_d = state_q;
    press_d = 1'b0;
    cnt_d   = cnt_q;
    if (key_in != last_q) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(DEB_CYCLES - 1)) begin
      cnt_d = CW'(cnt_q + CW'(1));
    end else if (key_in != state_q) begin
      state_d = key_in;
      press_d = state_q & ~key_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= 1'b1;
      state_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      last_q  <= last_d;
      state_q <= state_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/vga_box_mover.sv
// Bounces a BOX_W square inside the green frame interior, stepping on vsync rising edges.
// Optional pause push-button (key_n with debounce) when BOX_KEY_EN is defined.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int unsigned LEFT       = INT_LEFT,
  parameter int unsigned RIGHT      = INT_RIGHT,
  parameter int unsigned TOP        = INT_TOP,
  parameter int unsigned BOTTOM     = INT_BOTTOM,
  parameter int unsigned BOX_W      = 31,
  parameter int unsigned STEP       = 2,
  parameter int unsigned FRAME_DIV  = 1,
  parameter int unsigned X0         = 385,
  parameter int unsigned Y0         = 285,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       en,
`ifdef BOX_KEY_EN
  input  logic       key_n,
`endif
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic       frame_tick,
  output logic       hit
);

  localparam int unsigned XMAX = RIGHT - BOX_W + 1;
  localparam int unsigned YMAX = BOTTOM - BOX_W + 1;
  localparam int unsigned DW   = 8;

  logic          vsync_d_q, vsync_d_d;
  logic [9:0]    box_x_q, box_x_d;
  logic [9:0]    box_y_q, box_y_d;
  logic          dir_x_q, dir_x_d;
  logic          dir_y_q, dir_y_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          frame_tick_q, frame_tick_d;
  logic          hit_q, hit_d;
  logic          paused;
  logic          vsync_rise_c;
  axis_t         ax_c, ay_c;

`ifdef BOX_KEY_EN
  logic key_s1_q, key_s1_d;
  logic key_s2_q, key_s2_d;
  logic paused_q, paused_d;
  logic press;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_in (key_s2_q),
    .press  (press)
  );

  // Two-flop synchronizer on the asynchronous button, then toggle on each press.
  always_comb begin
    key_s1_d = key_n;
    key_s2_d = key_s1_q;
    paused_d = paused_q ^ press;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      paused_q <= 1'b0;
    end else begin
      key_s1_q <= key_s1_d;
      key_s2_q <= key_s2_d;
      paused_q <= paused_d;
    end
  end

  assign paused = paused_q;
`else
  assign paused = 1'b0;
`endif

  // vsync is already in this clock domain, so a single delay flop suffices.
  always_comb begin
    vsync_rise_c = vsync & ~vsync_d_q;
    ax_c = axis_step({1'b0, box_x_q}, dir_x_q, AXW'(LEFT), AXW'(XMAX), AXW'(STEP));
    ay_c = axis_step({1'b0, box_y_q}, dir_y_q, AXW'(TOP),  AXW'(YMAX), AXW'(STEP));

    vsync_d_d    = vsync;
    box_x_d      = box_x_q;
    box_y_d      = box_y_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    div_cnt_d    = div_cnt_q;
    frame_tick_d = vsync_rise_c;
    hit_d        = 1'b0;

    if (vsync_rise_c && en && !paused) begin
      if (div_cnt_q == DW'(FRAME_DIV - 1)) begin
        div_cnt_d = '0;
        box_x_d   = ax_c.pos[9:0];
        box_y_d   = ay_c.pos[9:0];
        dir_x_d   = ax_c.dir;
        dir_y_d   = ay_c.dir;
        hit_d     = ax_c.bounced | ay_c.bounced;
      end else begin
        div_cnt_d = DW'(div_cnt_q + DW'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d_q    <= 1'b1;
      box_x_q      <= 10'(X0);
      box_y_q      <= 10'(Y0);
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      div_cnt_q    <= '0;
      frame_tick_q <= 1'b0;
      hit_q        <= 1'b0;
    end else begin
      vsync_d_q    <= vsync_d_d;
      box_x_q      <= box_x_d;
      box_y_q      <= box_y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      div_cnt_q    <= div_cnt_d;
      frame_tick_q <= frame_tick_d;
      hit_q        <= hit_d;
    end
  end

  assign box_x      = box_x_q;
  assign box_y      = box_y_q;
  assign frame_tick = frame_tick_q;
  assign hit        = hit_q;

endmodule

// File: tb/tb_vga_box_mover.sv
// Directed bench for vga_box_mover: three instances (default, corner start, FRAME_DIV=3)
// plus the pause button sequence when BOX_KEY_EN is defined.
module tb_vga_box_mover;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_n, vsync, en0, en1, en2, key_n0, key_tie;
  logic [9:0] x0, y0, x1, y1, x2, y2;
  logic       t0, h0, t1, h1, t2, h2;
  int         n_assert = 0;
  int         n_fail   = 0;
  int         ticks;
  logic       bad;

  vga_box_mover #(.DEB_CYCLES(16)) u0 (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .en(en0),
`ifdef BOX_KEY_EN
    .key_n(key_n0),
`endif
    .box_x(x0), .box_y(y0), .frame_tick(t0), .hit(h0)
  );

  vga_box_mover #(.X0(547), .Y0(407), .DEB_CYCLES(16)) u1 (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .en(en1),
`ifdef BOX_KEY_EN
    .key_n(key_tie),
`endif
    .box_x(x1), .box_y(y1), .frame_tick(t1), .hit(h1)
  );

  vga_box_mover #(.FRAME_DIV(3), .DEB_CYCLES(16)) u2 (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .en(en2),
`ifdef BOX_KEY_EN
    .key_n(key_tie),
`endif
    .box_x(x2), .box_y(y2), .frame_tick(t2), .hit(h2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // vsync low for a few lines, then high; returns at the sample point after the rise.
  task automatic frame();
    @(negedge clk) vsync = 1'b0;
    repeat (4) @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; vsync = 1'b1; en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    key_n0 = 1'b1; key_tie = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_x", 32'(x0), 385);
    chk("reset_y", 32'(y0), 285);
    chk("reset_tick", 32'(t0), 0);
    chk("reset_hit", 32'(h0), 0);

    bad = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (x0 !== 10'd385 || y0 !== 10'd285 || t0 !== 1'b0 || h0 !== 1'b0) bad = 1'b1;
    end
    chk("idle_hold", 32'(bad), 0);

    en0 = 1'b1;
    frame();
    chk("f1_tick", 32'(t0), 1);
    chk("f1_x", 32'(x0), 387);
    chk("f1_y", 32'(y0), 287);
    chk("f1_hit", 32'(h0), 0);
    @(negedge clk);
    chk("f1_tick_once", 32'(t0), 0);
    chk("f1_x_hold", 32'(x0), 387);
    ticks = 1;

    for (int f = 2; f <= 83; f++) begin
      frame();
      ticks += int'(t0);
      if (f == 62) begin
        chk("f62_y", 32'(y0), 409);
        chk("f62_x", 32'(x0), 509);
        chk("f62_hit", 32'(h0), 1);
      end
      if (f == 63) begin
        chk("f63_y", 32'(y0), 407);
        chk("f63_hit", 32'(h0), 0);
      end
      if (f == 82) begin
        chk("f82_x", 32'(x0), 549);
        chk("f82_hit", 32'(h0), 1);
      end
      if (f == 83) begin
        chk("f83_x", 32'(x0), 547);
        chk("f83_hit", 32'(h0), 0);
      end
    end
    chk("tick_count", 32'(ticks), 83);
    en0 = 1'b0;

    chk("u1_hold_x", 32'(x1), 547);
    chk("u1_hold_y", 32'(y1), 407);
    en1 = 1'b1;
    frame();
    chk("corner_x", 32'(x1), 549);
    chk("corner_y", 32'(y1), 409);
    chk("corner_hit", 32'(h1), 1);
    @(negedge clk);
    chk("corner_hit_once", 32'(h1), 0);
    frame();
    chk("corner_back_x", 32'(x1), 547);
    chk("corner_back_y", 32'(y1), 407);
    chk("corner_back_hit", 32'(h1), 0);
    for (int j = 1; j <= 124; j++) begin
      frame();
      if (j == 123) begin
        chk("top_y", 32'(y1), 161);
        chk("top_x", 32'(x1), 301);
        chk("top_hit", 32'(h1), 1);
      end
      if (j == 124) begin
        chk("top_back_y", 32'(y1), 163);
        chk("top_back_x", 32'(x1), 299);
        chk("top_back_hit", 32'(h1), 0);
      end
    end
    en1 = 1'b0;

    en2 = 1'b1;
    frame();
    chk("div_t1_x", 32'(x2), 385);
    chk("div_t1_tick", 32'(t2), 1);
    frame();
    chk("div_t2_x", 32'(x2), 385);
    en2 = 1'b0;
    frame();
    chk("div_off1_tick", 32'(t2), 1);
    chk("div_off1_x", 32'(x2), 385);
    frame();
    chk("div_off2_tick", 32'(t2), 1);
    chk("div_off2_x", 32'(x2), 385);
    en2 = 1'b1;
    frame();
    chk("div_t3_x", 32'(x2), 387);
    chk("div_t3_y", 32'(y2), 287);
    frame();
    chk("div_t4_x", 32'(x2), 387);
    frame();
    chk("div_t5_x", 32'(x2), 387);
    frame();
    chk("div_t6_x", 32'(x2), 389);
    chk("div_t6_y", 32'(y2), 289);

    en0 = 1'b1;
    @(negedge clk) vsync = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_x0", 32'(x0), 385);
    chk("midrst_y0", 32'(y0), 285);
    chk("midrst_x1", 32'(x1), 547);
    chk("midrst_x2", 32'(x2), 385);
    chk("midrst_y2", 32'(y2), 285);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) vsync = 1'b1;
    @(negedge clk);
    chk("post_rst_tick", 32'(t0), 1);
    chk("post_rst_x", 32'(x0), 387);
    chk("post_rst_y", 32'(y0), 287);

`ifdef BOX_KEY_EN
    for (int b = 0; b < 3; b++) begin
      key_n0 = 1'b0;
      repeat (5) @(negedge clk);
      key_n0 = 1'b1;
      repeat (5) @(negedge clk);
    end
    key_n0 = 1'b0;
    repeat (40) @(negedge clk);
    key_n0 = 1'b1;
    repeat (40) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      frame();
      chk("pause_tick", 32'(t0), 1);
      chk("pause_x", 32'(x0), 387);
      chk("pause_y", 32'(y0), 287);
    end
    key_n0 = 1'b0;
    repeat (40) @(negedge clk);
    key_n0 = 1'b1;
    repeat (40) @(negedge clk);
    frame();
    chk("resume_x", 32'(x0), 389);
    chk("resume_y", 32'(y0), 289);
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
